// File: rtl/calendar_counter_pkg.sv
// Shared calendar encodings: month and day-of-week values plus leap-rule selectors.
package calendar_counter_pkg;

  typedef enum logic [3:0] {
    JAN = 4'd1, FEB, MAR, APR, MAY, JUN, JUL, AUG, SEP, OCT, NOV, DEC
  } month_e;

  typedef enum logic [2:0] {
    SUN = 3'd0, MON, TUE, WED, THU, FRI, SAT
  } dow_e;

  localparam int LEAP_SIMPLE = 0;
  localparam int LEAP_GREG   = 1;

endpackage

// File: rtl/calendar_counter_month_length.sv
// Combinational month length and leap flag for a given year/month.
// Out-of-range months decode to 31; callers range-check the month themselves.
module calendar_counter_month_length
  import calendar_counter_pkg::*;
#(
  parameter int YEAR_W    = 12,
  parameter int LEAP_MODE = LEAP_GREG
) (
  input  logic [YEAR_W-1:0] i_year,
  input  logic [3:0]        i_month,
  output logic [4:0]        o_days,
  output logic              o_leap
);

  logic [31:0] w_year32;
  logic        w_div4;
  logic        w_div100;
  logic        w_div400;

  // Divisibility is evaluated on a zero-extended copy; YEAR_W is limited to 31 bits.
  assign w_year32 = 32'(i_year);
  assign w_div4   = (w_year32[1:0] == 2'd0);
  assign w_div100 = ((w_year32 % 32'd100) == 32'd0);
  assign w_div400 = ((w_year32 % 32'd400) == 32'd0);

  assign o_leap = (LEAP_MODE == LEAP_SIMPLE) ? w_div4
                                             : (w_div4 & (~w_div100 | w_div400));

  always_comb begin
    o_days = 5'd31;
    case (i_month)
      4'(FEB):                         o_days = o_leap ? 5'd29 : 5'd28;
      4'(APR), 4'(JUN), 4'(SEP), 4'(NOV): o_days = 5'd30;
      default:                         o_days = 5'd31;
    endcase
  end

endmodule

// File: rtl/calendar_counter.sv
// Registered year/month/day/day-of-week keeper: advances on day_tick, accepts validated loads.
module calendar_counter
  import calendar_counter_pkg::*;
#(
  parameter int YEAR_W    = 12,
  parameter int LEAP_MODE = LEAP_GREG,
  parameter int RST_YEAR  = 2015,
  parameter int RST_MONTH = 1,
  parameter int RST_DAY   = 1,
  parameter int RST_DOW   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_day_tick,
  input  logic              i_load,
  input  logic [YEAR_W-1:0] i_ld_year,
  input  logic [3:0]        i_ld_month,
  input  logic [4:0]        i_ld_day,
  input  logic [2:0]        i_ld_dow,
  output logic [YEAR_W-1:0] o_year,
  output logic [3:0]        o_month,
  output logic [4:0]        o_day,
  output logic [2:0]        o_dow,
  output logic [4:0]        o_days_in_month,
  output logic              o_leap,
  output logic              o_month_end,
  output logic              o_year_wrap,
  output logic              o_load_err
);

  logic [YEAR_W-1:0] r_year;
  logic [3:0]        r_month;
  logic [4:0]        r_day;
  logic [2:0]        r_dow;
  logic              r_month_end;
  logic              r_year_wrap;
  logic              r_load_err;

  logic [4:0] w_cur_days;
  logic       w_cur_leap;
  logic [4:0] w_ld_days;
  logic       w_unused_ld_leap;
  logic       w_load_ok;

  calendar_counter_month_length #(.YEAR_W(YEAR_W), .LEAP_MODE(LEAP_MODE)) u_len_cur (
    .i_year  (r_year),
    .i_month (r_month),
    .o_days  (w_cur_days),
    .o_leap  (w_cur_leap)
  );

  calendar_counter_month_length #(.YEAR_W(YEAR_W), .LEAP_MODE(LEAP_MODE)) u_len_ld (
    .i_year  (i_ld_year),
    .i_month (i_ld_month),
    .o_days  (w_ld_days),
    .o_leap  (w_unused_ld_leap)
  );

  // Day-of-week is not cross-checked against the loaded date.
  assign w_load_ok = (i_ld_month >= 4'(JAN)) && (i_ld_month <= 4'(DEC)) &&
                     (i_ld_day != 5'd0) && (i_ld_day <= w_ld_days) &&
                     (i_ld_dow <= 3'(SAT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_year      <= YEAR_W'(RST_YEAR);
      r_month     <= 4'(RST_MONTH);
      r_day       <= 5'(RST_DAY);
      r_dow       <= 3'(RST_DOW);
      r_month_end <= 1'b0;
      r_year_wrap <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_month_end <= 1'b0;
      r_year_wrap <= 1'b0;
      r_load_err  <= 1'b0;
      if (i_load) begin
        if (w_load_ok) begin
          r_year  <= i_ld_year;
          r_month <= i_ld_month;
          r_day   <= i_ld_day;
          r_dow   <= i_ld_dow;
        end else begin
          r_load_err <= 1'b1;
        end
      end else if (i_day_tick) begin
        r_dow <= (r_dow == 3'(SAT)) ? 3'(SUN) : r_dow + 3'd1;
        if (r_day < w_cur_days) begin
          r_day <= r_day + 5'd1;
        end else begin
          r_day       <= 5'd1;
          r_month_end <= 1'b1;
          if (r_month < 4'(DEC)) begin
            r_month <= r_month + 4'd1;
          end else begin
            r_month     <= 4'(JAN);
            r_year      <= r_year + YEAR_W'(1);
            r_year_wrap <= &r_year;
          end
        end
      end
    end
  end

  assign o_year          = r_year;
  assign o_month         = r_month;
  assign o_day           = r_day;
  assign o_dow           = r_dow;
  assign o_days_in_month = w_cur_days;
  assign o_leap          = w_cur_leap;
  assign o_month_end     = r_month_end;
  assign o_year_wrap     = r_year_wrap;
  assign o_load_err      = r_load_err;

endmodule
